// File: rtl/ds2x2_pkg.sv
// rtl/ds2x2_pkg.sv - shared types and constants for the 2x2 downscaler control sequencer
package ds2x2_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    HUNT,
    EVEN_LINE,
    ODD_LINE
  } state_t;

  typedef struct packed {
    logic hsum_load;
    logic hsum_add;
    logic lb_wr;
    logic lb_rd;
    logic out_push;
    logic out_tuser;
    logic out_tlast;
  } strobe_t;

endpackage

// File: rtl/downscaler_2x2_ctrl_pos_cnt.sv
// rtl/downscaler_2x2_ctrl_pos_cnt.sv - in-line position: pixel phase, pair count, even-line width capture
module ds2x2_pos_cnt #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              restart,
  input  logic              clear,
  input  logic              capture,
  output logic              phase,
  output logic [ADDR_W-1:0] pair,
  output logic              at_start,
  output logic              pair_last,
  output logic [ADDR_W:0]   even_pairs
);

  logic              pix_phase;
  logic [ADDR_W-1:0] pair_cnt;

  // A restarted beat is column 0 regardless of where the abandoned line was.
  assign phase     = restart ? 1'b0 : pix_phase;
  assign pair      = restart ? '0 : pair_cnt;
  assign at_start  = ~pix_phase & (pair_cnt == '0);
  assign pair_last = &pair;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_phase  <= 1'b0;
      pair_cnt   <= '0;
      even_pairs <= '0;
    end else begin
      if (clear) begin
        pix_phase <= 1'b0;
        pair_cnt  <= '0;
      end else if (beat) begin
        pix_phase <= ~phase;
        pair_cnt  <= phase ? pair + ADDR_W'(1) : pair;
      end
      if (capture) begin
        even_pairs <= (ADDR_W+1)'(pair) + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/downscaler_2x2_ctrl.sv
// rtl/downscaler_2x2_ctrl.sv - 2x2 downscaler control sequencer (optional DS2X2_CTRL_STATS_EN counters)
module downscaler_2x2_ctrl
  import ds2x2_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic              up_tuser,
  input  logic              up_tlast,
  output logic              up_ready,
  input  logic              out_fifo_afull,
  output logic              hsum_load,
  output logic              hsum_add,
  output logic              lb_wr,
  output logic              lb_rd,
  output logic [ADDR_W-1:0] lb_addr,
  output logic              out_push,
  output logic              out_tuser,
  output logic              out_tlast,
  output logic              frame_locked,
  output logic              err_geom,
  output logic              err_sof
`ifdef DS2X2_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] frame_cnt,
  output logic [STATS_W-1:0] err_cnt
`endif
);

  state_t            state, nxt, line;
  strobe_t           strb_d, strb_q;
  logic [ADDR_W-1:0] addr_d, pair;
  logic [ADDR_W:0]   even_pairs, pair_next;
  logic              accept, beat, phase, at_start, pair_last;
  logic              geom_d, sof_d, sof_pending, sof_nxt, clear, capture;

  assign up_ready     = (state != ODD_LINE) | ~out_fifo_afull;
  assign accept       = up_valid & up_ready;
  assign beat         = accept & (up_tuser | (state != HUNT));
  assign frame_locked = (state != HUNT);
  assign pair_next    = (ADDR_W+1)'(pair) + (ADDR_W+1)'(1);

  ds2x2_pos_cnt #(.ADDR_W(ADDR_W)) u_pos (
    .clk        (clk),
    .rst        (rst),
    .beat       (beat),
    .restart    (accept & up_tuser),
    .clear      (clear),
    .capture    (capture),
    .phase      (phase),
    .pair       (pair),
    .at_start   (at_start),
    .pair_last  (pair_last),
    .even_pairs (even_pairs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      strb_q      <= '0;
      lb_addr     <= '0;
      err_geom    <= 1'b0;
      err_sof     <= 1'b0;
      sof_pending <= 1'b0;
    end else begin
      state       <= nxt;
      strb_q      <= strb_d;
      lb_addr     <= addr_d;
      err_geom    <= geom_d;
      err_sof     <= sof_d;
      sof_pending <= sof_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    line    = state;
    strb_d  = '0;
    addr_d  = '0;
    geom_d  = 1'b0;
    sof_d   = 1'b0;
    sof_nxt = sof_pending;
    clear   = 1'b0;
    capture = 1'b0;
    // SOF is resolved first so a combined tuser+tlast beat sees a fresh column 0.
    if (accept && up_tuser) begin
      sof_d   = (state == ODD_LINE) || ((state == EVEN_LINE) && !at_start);
      sof_nxt = 1'b1;
      line    = EVEN_LINE;
      nxt     = EVEN_LINE;
    end
    if (beat) begin
      if (!phase) begin
        strb_d.hsum_load = 1'b1;
        if (up_tlast) begin
          geom_d = 1'b1;
          nxt    = HUNT;
          clear  = 1'b1;
        end
      end else begin
        strb_d.hsum_add = 1'b1;
        addr_d          = pair;
        if (line == EVEN_LINE) begin
          strb_d.lb_wr = 1'b1;
        end else begin
          strb_d.lb_rd     = 1'b1;
          strb_d.out_push  = 1'b1;
          strb_d.out_tuser = sof_pending;
          strb_d.out_tlast = up_tlast;
          sof_nxt          = 1'b0;
        end
        if (up_tlast) begin
          clear = 1'b1;
          if (line == EVEN_LINE) begin
            capture = 1'b1;
            nxt     = ODD_LINE;
          end else begin
            geom_d = (pair_next != even_pairs);
            nxt    = EVEN_LINE;
          end
        end else if (pair_last) begin
          geom_d = 1'b1;
          nxt    = HUNT;
          clear  = 1'b1;
        end
      end
    end
  end

  assign hsum_load = strb_q.hsum_load;
  assign hsum_add  = strb_q.hsum_add;
  assign lb_wr     = strb_q.lb_wr;
  assign lb_rd     = strb_q.lb_rd;
  assign out_push  = strb_q.out_push;
  assign out_tuser = strb_q.out_tuser;
  assign out_tlast = strb_q.out_tlast;

`ifdef DS2X2_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (strb_d.out_push && strb_d.out_tuser && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + STATS_W'(1);
      end
      if ((geom_d || sof_d) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + STATS_W'(1);
      end
    end
  end
`endif

endmodule
